// File: rtl/switch_debounce_filter.sv
// Push-button conditioner: synchronises a raw switch into i_Clk and qualifies level changes
// with a stability counter. Optional edge strobes when SWITCH_DEBOUNCE_EDGE_EN is defined.
module switch_debounce_filter #(
  parameter int unsigned CLKS_TO_STABLE = 250000,
  parameter int unsigned SYNC_STAGES    = 2,
  parameter logic        INIT_LEVEL     = 1'b0
) (
  input  logic i_Clk,
  input  logic i_Rst_L,
  input  logic i_Switch,
  output logic o_Switch,
  output logic o_Rise,
  output logic o_Fall
);

  localparam int unsigned CntW    = $clog2(CLKS_TO_STABLE + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(CLKS_TO_STABLE - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CntW-1:0]        cnt_q;
  logic                   switch_q;
  logic                   w_sync;
  logic                   differ;
  logic                   update;

  assign w_sync = sync_q[SYNC_STAGES-1];
  assign differ = (w_sync != switch_q);
  assign update = differ && (cnt_q == CntLast);

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      sync_q <= {SYNC_STAGES{INIT_LEVEL}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], i_Switch};
    end
  end

  // Any cycle where the synchronised input matches the output discards progress.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      cnt_q    <= '0;
      switch_q <= INIT_LEVEL;
    end else if (!differ) begin
      cnt_q <= '0;
    end else if (update) begin
      cnt_q    <= '0;
      switch_q <= w_sync;
    end else begin
      cnt_q <= cnt_q + CntW'(1);
    end
  end

  assign o_Switch = switch_q;

`ifdef SWITCH_DEBOUNCE_EDGE_EN
  logic rise_q;
  logic fall_q;

  // Registered alongside switch_q so a strobe coincides with the first cycle of the new level.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      rise_q <= update &  w_sync;
      fall_q <= update & ~w_sync;
    end
  end

  assign o_Rise = rise_q;
  assign o_Fall = fall_q;
`else
  assign o_Rise = 1'b0;
  assign o_Fall = 1'b0;
`endif

endmodule

// File: tb/tb_switch_debounce_filter.sv
// Directed bench for switch_debounce_filter with CLKS_TO_STABLE=4, SYNC_STAGES=2, INIT_LEVEL=0.
module tb_switch_debounce_filter;

`ifdef SWITCH_DEBOUNCE_EDGE_EN
  localparam bit EdgeEn = 1'b1;
`else
  localparam bit EdgeEn = 1'b0;
`endif

  logic i_Clk;
  logic i_Rst_L;
  logic i_Switch;
  logic o_Switch;
  logic o_Rise;
  logic o_Fall;

  int n_checks;
  int n_fails;

  switch_debounce_filter #(
    .CLKS_TO_STABLE(4),
    .SYNC_STAGES   (2),
    .INIT_LEVEL    (1'b0)
  ) dut (
    .i_Clk   (i_Clk),
    .i_Rst_L (i_Rst_L),
    .i_Switch(i_Switch),
    .o_Switch(o_Switch),
    .o_Rise  (o_Rise),
    .o_Fall  (o_Fall)
  );

  initial i_Clk = 1'b0;
  always #5 i_Clk = ~i_Clk;

  // Inputs change and outputs are sampled on the falling edge; each tick passes one posedge.
  task automatic tick(input int n);
    repeat (n) @(negedge i_Clk);
  endtask

  task automatic test_reset();
    i_Rst_L  = 1'b0;
    i_Switch = 1'b1;
    tick(3);
    n_checks++;
    if (o_Switch !== 1'b0) begin
      n_fails++; $display("FAIL reset_level: got %b exp 0", o_Switch);
    end
    n_checks++;
    if (o_Rise !== 1'b0 || o_Fall !== 1'b0) begin
      n_fails++; $display("FAIL reset_strobes: got rise=%b fall=%b exp 0/0", o_Rise, o_Fall);
    end
    i_Rst_L = 1'b1;
    tick(1);
    n_checks++;
    if (o_Rise !== 1'b0 || o_Fall !== 1'b0) begin
      n_fails++; $display("FAIL release_strobes: got rise=%b fall=%b exp 0/0", o_Rise, o_Fall);
    end
    tick(4);
    n_checks++;
    if (o_Switch !== 1'b0) begin
      n_fails++; $display("FAIL reset_edge5: got %b exp 0", o_Switch);
    end
    tick(1);
    n_checks++;
    if (o_Switch !== 1'b1) begin
      n_fails++; $display("FAIL reset_edge6: got %b exp 1", o_Switch);
    end
    n_checks++;
    if (o_Rise !== EdgeEn || o_Fall !== 1'b0) begin
      n_fails++;
      $display("FAIL reset_rise: got rise=%b fall=%b exp %b/0", o_Rise, o_Fall, EdgeEn);
    end
    tick(1);
    n_checks++;
    if (o_Rise !== 1'b0 || o_Switch !== 1'b1) begin
      n_fails++; $display("FAIL reset_rise_off: got rise=%b sw=%b exp 0/1", o_Rise, o_Switch);
    end
  endtask

  task automatic test_release();
    i_Switch = 1'b0;
    tick(5);
    n_checks++;
    if (o_Switch !== 1'b1 || o_Fall !== 1'b0) begin
      n_fails++; $display("FAIL release_edge5: got sw=%b fall=%b exp 1/0", o_Switch, o_Fall);
    end
    tick(1);
    n_checks++;
    if (o_Switch !== 1'b0) begin
      n_fails++; $display("FAIL release_edge6: got %b exp 0", o_Switch);
    end
    n_checks++;
    if (o_Fall !== EdgeEn || o_Rise !== 1'b0) begin
      n_fails++;
      $display("FAIL release_fall: got fall=%b rise=%b exp %b/0", o_Fall, o_Rise, EdgeEn);
    end
    tick(1);
    n_checks++;
    if (o_Fall !== 1'b0 || o_Switch !== 1'b0) begin
      n_fails++; $display("FAIL release_fall_off: got fall=%b sw=%b exp 0/0", o_Fall, o_Switch);
    end
    tick(2);
  endtask

  task automatic test_bounce();
    int bad = 0;
    for (int c = 0; c < 20; c++) begin
      i_Switch = ((c / 2) % 2 == 0) ? 1'b1 : 1'b0;
      tick(1);
      if (o_Switch !== 1'b0 || o_Rise !== 1'b0 || o_Fall !== 1'b0) bad++;
    end
    i_Switch = 1'b0;
    for (int c = 0; c < 8; c++) begin
      tick(1);
      if (o_Switch !== 1'b0 || o_Rise !== 1'b0 || o_Fall !== 1'b0) bad++;
    end
    n_checks++;
    if (bad !== 0) begin
      n_fails++; $display("FAIL bounce: got %0d bad cycles exp 0", bad);
    end
  endtask

  task automatic test_clean_press();
    int bad = 0;
    i_Switch = 1'b1;
    tick(5);
    n_checks++;
    if (o_Switch !== 1'b0 || o_Rise !== 1'b0) begin
      n_fails++; $display("FAIL press_edge5: got sw=%b rise=%b exp 0/0", o_Switch, o_Rise);
    end
    tick(1);
    n_checks++;
    if (o_Switch !== 1'b1 || o_Rise !== EdgeEn || o_Fall !== 1'b0) begin
      n_fails++;
      $display("FAIL press_edge6: got sw=%b rise=%b fall=%b exp 1/%b/0",
               o_Switch, o_Rise, o_Fall, EdgeEn);
    end
    for (int c = 0; c < 4; c++) begin
      tick(1);
      if (o_Switch !== 1'b1 || o_Rise !== 1'b0 || o_Fall !== 1'b0) bad++;
    end
    n_checks++;
    if (bad !== 0) begin
      n_fails++; $display("FAIL press_hold: got %0d bad cycles exp 0", bad);
    end
  endtask

  task automatic test_late_bounce();
    int bad = 0;
    // Three synchronised high cycles take the count to N-1; the low cycle must then restart it.
    i_Switch = 1'b1;
    tick(3);
    i_Switch = 1'b0;
    tick(1);
    i_Switch = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick(1);
      if (o_Switch !== 1'b0 || o_Rise !== 1'b0) bad++;
    end
    n_checks++;
    if (bad !== 0) begin
      n_fails++; $display("FAIL late_bounce_hold: got %0d early cycles exp 0", bad);
    end
    tick(1);
    n_checks++;
    if (o_Switch !== 1'b1 || o_Rise !== EdgeEn) begin
      n_fails++;
      $display("FAIL late_bounce_rise: got sw=%b rise=%b exp 1/%b", o_Switch, o_Rise, EdgeEn);
    end
    tick(2);
  endtask

  task automatic test_mid_reset();
    i_Switch = 1'b1;
    tick(4);
    i_Rst_L = 1'b0;
    #1;
    n_checks++;
    if (o_Switch !== 1'b0 || o_Rise !== 1'b0 || o_Fall !== 1'b0) begin
      n_fails++;
      $display("FAIL midreset_low: got sw=%b rise=%b fall=%b exp 0/0/0", o_Switch, o_Rise, o_Fall);
    end
    tick(1);
    i_Rst_L = 1'b1;
    tick(5);
    n_checks++;
    if (o_Switch !== 1'b0) begin
      n_fails++; $display("FAIL midreset_edge5: got %b exp 0", o_Switch);
    end
    tick(1);
    n_checks++;
    if (o_Switch !== 1'b1 || o_Rise !== EdgeEn) begin
      n_fails++;
      $display("FAIL midreset_edge6: got sw=%b rise=%b exp 1/%b", o_Switch, o_Rise, EdgeEn);
    end
    tick(2);
    // Reset while qualifying a fall: output must drop to INIT_LEVEL at once, no strobe.
    i_Switch = 1'b0;
    tick(4);
    n_checks++;
    if (o_Switch !== 1'b1) begin
      n_fails++; $display("FAIL midreset_fall_pre: got %b exp 1", o_Switch);
    end
    i_Rst_L = 1'b0;
    #1;
    n_checks++;
    if (o_Switch !== 1'b0 || o_Rise !== 1'b0 || o_Fall !== 1'b0) begin
      n_fails++;
      $display("FAIL midreset_async: got sw=%b rise=%b fall=%b exp 0/0/0",
               o_Switch, o_Rise, o_Fall);
    end
    tick(1);
    i_Rst_L = 1'b1;
    tick(8);
    n_checks++;
    if (o_Switch !== 1'b0 || o_Fall !== 1'b0) begin
      n_fails++; $display("FAIL midreset_after: got sw=%b fall=%b exp 0/0", o_Switch, o_Fall);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;
    i_Rst_L  = 1'b0;
    i_Switch = 1'b0;
    test_reset();
    test_release();
    test_bounce();
    test_clean_press();
    test_release();
    test_late_bounce();
    test_release();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout exp completion");
    $fatal(1, "timeout");
  end

endmodule
